// File: rtl/riscv_pkg.sv
// Shared definitions for the unified-memory arbiter and the data memory:
// arbiter state/port encodings and the funct3 access-width codes.
package riscv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    localparam logic [2:0] W_BYTE = 3'b000;
    localparam logic [2:0] W_HALF = 3'b001;
    localparam logic [2:0] W_WORD = 3'b010;
    localparam logic [2:0] W_BU   = 3'b100;
    localparam logic [2:0] W_HU   = 3'b101;

endpackage

// File: rtl/arb_pick.sv
// Two-way requester pick. A lone requester always wins; on a tie the
// winner is D when FIXED_PRIO is set, otherwise whichever port did not
// own the memory last (round-robin).
module arb_pick
    import riscv_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_owner_i,
    output logic owner_o,
    output logic valid_o
);

    // Select the owner for the next transaction from the current requests.
    always_comb begin
        valid_o = i_req_i | d_req_i;
        owner_o = PORT_I;
        if (i_req_i && d_req_i) begin
            if (FIXED_PRIO != 0) begin
                owner_o = PORT_D;
            end else if (last_owner_i == PORT_I) begin
                owner_o = PORT_D;
            end else begin
                owner_o = PORT_I;
            end
        end else if (d_req_i) begin
            owner_o = PORT_D;
        end else begin
            owner_o = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (port I) and
// load/store (port D). One transaction is outstanding at a time; a
// watchdog aborts a transaction the memory never completes.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port (read-only, word accesses)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    // load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least 1 bit.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit              WD_EN   = (TIMEOUT > 0);

    arb_state_t        state_q;
    arb_port_t         owner_q;
    arb_port_t         last_owner_q;
    logic [CNT_W-1:0]  wd_q;

    logic              i_gnt_q, d_gnt_q;
    logic              i_rvalid_q, d_rvalid_q;
    logic              i_err_q, d_err_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              mem_req_q, mem_we_q;
    logic [2:0]        mem_width_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              pick_owner_s;
    logic              pick_valid_s;
    logic              done_s;
    logic              fail_s;
    logic [DATA_W-1:0] cpl_rdata_s;

    arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .last_owner_i (last_owner_q),
        .owner_o      (pick_owner_s),
        .valid_o      (pick_valid_s)
    );

    // Decide whether the BUSY transaction ends this cycle and with what data;
    // a memory response wins over a watchdog expiry in the same cycle.
    always_comb begin
        done_s      = 1'b0;
        fail_s      = 1'b0;
        cpl_rdata_s = '0;
        if (state_q == BUSY) begin
            if (mem_ready) begin
                done_s = 1'b1;
            end else if (WD_EN && (wd_q == WD_LAST)) begin
                done_s = 1'b1;
                fail_s = 1'b1;
            end else begin
                done_s = 1'b0;
            end
        end else begin
            done_s = 1'b0;
        end
        if (fail_s || mem_we_q) begin
            cpl_rdata_s = '0;
        end else begin
            cpl_rdata_s = mem_rdata;
        end
    end

    // Arbitration FSM: grant in IDLE, hold the memory request in BUSY,
    // complete on mem_ready or watchdog expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            last_owner_q <= PORT_D;
            wd_q         <= '0;
            i_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_width_q  <= 3'b000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // grant/complete indications are single-cycle pulses
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        owner_q   <= arb_port_t'(pick_owner_s);
                        mem_req_q <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= BUSY;
                        if (pick_owner_s == PORT_D) begin
                            d_gnt_q     <= 1'b1;
                            mem_we_q    <= d_we;
                            mem_width_q <= d_width;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            i_gnt_q     <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_width_q <= W_WORD;
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= '0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        mem_req_q    <= 1'b0;
                        last_owner_q <= owner_q;
                        wd_q         <= '0;
                        state_q      <= IDLE;
                        if (owner_q == PORT_D) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= fail_s;
                            d_rdata_q  <= cpl_rdata_s;
                        end else begin
                            i_rvalid_q <= 1'b1;
                            i_err_q    <= fail_s;
                            i_rdata_q  <= cpl_rdata_s;
                        end
                    end else if (WD_EN) begin
                        wd_q <= wd_q + CNT_W'(1);
                    end else begin
                        wd_q <= wd_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_gnt     = i_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_width = mem_width_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (rr) and a fixed-priority
// instance (fp) share stimulus; both use a 4-cycle watchdog.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_width;

    logic        rr_i_gnt, rr_i_rvalid, rr_i_err, rr_d_gnt, rr_d_rvalid, rr_d_err;
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_mem_addr, rr_mem_wdata;
    logic        rr_mem_req, rr_mem_we;
    logic [2:0]  rr_mem_width;
    logic        fp_i_gnt, fp_i_rvalid, fp_i_err, fp_d_gnt, fp_d_rvalid, fp_d_err;
    logic [31:0] fp_i_rdata, fp_d_rdata, fp_mem_addr, fp_mem_wdata;
    logic        fp_mem_req, fp_mem_we;
    logic [2:0]  fp_mem_width;

    typedef struct {
        logic        port;   // 0 = I, 1 = D
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(4)) dut_rr (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(rr_i_gnt), .i_rvalid(rr_i_rvalid),
        .i_rdata(rr_i_rdata), .i_err(rr_i_err),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(rr_d_gnt), .d_rvalid(rr_d_rvalid), .d_rdata(rr_d_rdata), .d_err(rr_d_err),
        .mem_req(rr_mem_req), .mem_we(rr_mem_we), .mem_width(rr_mem_width),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(4)) dut_fp (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(fp_i_gnt), .i_rvalid(fp_i_rvalid),
        .i_rdata(fp_i_rdata), .i_err(fp_i_err),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata), .d_err(fp_d_err),
        .mem_req(fp_mem_req), .mem_we(fp_mem_we), .mem_width(fp_mem_width),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req     = 1'b0;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_width   = 3'b000;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if ({rr_i_gnt, rr_d_gnt, rr_i_rvalid, rr_d_rvalid, rr_i_err, rr_d_err, rr_mem_req} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got=%b exp=0000000",
                     {rr_i_gnt, rr_d_gnt, rr_i_rvalid, rr_d_rvalid, rr_i_err, rr_d_err, rr_mem_req});
        end
        total++;
        if ({rr_mem_addr, rr_mem_wdata, rr_i_rdata, rr_d_rdata} !== 128'h0 || rr_mem_width !== 3'b000
            || rr_mem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h irdata=%h drdata=%h width=%b we=%b exp all 0",
                     rr_mem_addr, rr_mem_wdata, rr_i_rdata, rr_d_rdata, rr_mem_width, rr_mem_we);
        end
        // mem_ready while IDLE must do nothing
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        total++;
        if ({rr_mem_req, rr_i_rvalid, rr_d_rvalid} !== 3'b000) begin
            bad++;
            $display("FAIL idle_ready_ignored: got=%b exp=000", {rr_mem_req, rr_i_rvalid, rr_d_rvalid});
        end
    endtask

    task automatic test_single_fetch();
        exp_t e;
        do_reset(2);
        i_req  = 1'b1;
        i_addr = 32'h0000_0010;
        step();                                   // N+1
        i_req = 1'b0;
        total++;
        if ({rr_i_gnt, rr_d_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_gnt: got=%b exp=10", {rr_i_gnt, rr_d_gnt});
        end
        total++;
        if (rr_mem_req !== 1'b1 || rr_mem_addr !== 32'h10 || rr_mem_we !== 1'b0 || rr_mem_width !== 3'b010) begin
            bad++;
            $display("FAIL fetch_mem: got req=%b addr=%h we=%b width=%b exp 1/00000010/0/010",
                     rr_mem_req, rr_mem_addr, rr_mem_we, rr_mem_width);
        end
        step();                                   // N+2
        total++;
        if (rr_i_rvalid !== 1'b0 || rr_i_gnt !== 1'b0 || rr_mem_addr !== 32'h10) begin
            bad++;
            $display("FAIL fetch_busy: got rvalid=%b gnt=%b addr=%h exp 0/0/00000010",
                     rr_i_rvalid, rr_i_gnt, rr_mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        sb_q.push_back('{port: 1'b0, data: 32'h0050_0093, err: 1'b0});
        step();                                   // N+3
        mem_ready = 1'b0;
        total++;
        if (rr_i_rvalid !== 1'b1 || sb_q.size() == 0) begin
            bad++;
            $display("FAIL fetch_rvalid: got=%b exp=1", rr_i_rvalid);
        end else begin
            e = sb_q.pop_front();
            total++;
            if (rr_i_rdata !== e.data || rr_i_err !== e.err || rr_mem_req !== 1'b0) begin
                bad++;
                $display("FAIL fetch_data: got rdata=%h err=%b mem_req=%b exp %h/%b/0",
                         rr_i_rdata, rr_i_err, rr_mem_req, e.data, e.err);
            end
        end
    endtask

    // Both ports request continuously; memory answers on the first BUSY cycle.
    task automatic test_tie(input bit fp);
        exp_t        e;
        logic [1:0]  gnt, rv, exp_gnt;
        logic [31:0] rd;
        do_reset(1);
        i_req     = 1'b1;
        d_req     = 1'b1;
        i_addr    = 32'h100;
        d_addr    = 32'h200;
        mem_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            gnt = fp ? {fp_i_gnt, fp_d_gnt} : {rr_i_gnt, rr_d_gnt};
            rv  = fp ? {fp_i_rvalid, fp_d_rvalid} : {rr_i_rvalid, rr_d_rvalid};
            if (k % 2 == 1) begin
                if (fp)
                    exp_gnt = 2'b01;
                else
                    exp_gnt = (k % 4 == 1) ? 2'b10 : 2'b01;
            end else begin
                exp_gnt = 2'b00;
            end
            total++;
            if (gnt !== exp_gnt) begin
                bad++;
                $display("FAIL tie_gnt fp=%0d k=%0d: got=%b exp=%b", fp, k, gnt, exp_gnt);
            end
            if (k % 2 == 1) begin
                mem_rdata = 32'h1000 + k;
                sb_q.push_back('{port: exp_gnt[0], data: 32'h1000 + k, err: 1'b0});
            end else begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL tie_sb_empty fp=%0d k=%0d: got=0 exp=1 entries", fp, k);
                end else begin
                    e  = sb_q.pop_front();
                    rd = e.port ? (fp ? fp_d_rdata : rr_d_rdata) : (fp ? fp_i_rdata : rr_i_rdata);
                    if (rv !== (e.port ? 2'b01 : 2'b10) || rd !== e.data) begin
                        bad++;
                        $display("FAIL tie_rvalid fp=%0d k=%0d: got rv=%b rdata=%h exp rv=%b rdata=%h",
                                 fp, k, rv, rd, (e.port ? 2'b01 : 2'b10), e.data);
                    end
                end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_store();
        exp_t e;
        do_reset(1);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_width = 3'b000;
        d_addr  = 32'h0000_0103;
        d_wdata = 32'h0000_00AB;
        step();
        d_req = 1'b0;
        total++;
        if ({rr_i_gnt, rr_d_gnt} !== 2'b01 || rr_mem_we !== 1'b1 || rr_mem_width !== 3'b000
            || rr_mem_addr !== 32'h103 || rr_mem_wdata !== 32'hAB) begin
            bad++;
            $display("FAIL store_mem: got gnt=%b we=%b width=%b addr=%h wdata=%h exp 01/1/000/00000103/000000ab",
                     {rr_i_gnt, rr_d_gnt}, rr_mem_we, rr_mem_width, rr_mem_addr, rr_mem_wdata);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        sb_q.push_back('{port: 1'b1, data: 32'h0, err: 1'b0});
        step();
        mem_ready = 1'b0;
        e = sb_q.pop_front();
        total++;
        if (rr_d_rvalid !== 1'b1 || rr_i_rvalid !== 1'b0 || rr_d_rdata !== e.data || rr_d_err !== e.err) begin
            bad++;
            $display("FAIL store_rvalid: got rvalid=%b irv=%b rdata=%h err=%b exp 1/0/%h/%b",
                     rr_d_rvalid, rr_i_rvalid, rr_d_rdata, rr_d_err, e.data, e.err);
        end
    endtask

    // Fetch with no response (abort), response on the last cycle, then abort again.
    task automatic test_watchdog();
        exp_t e;
        logic ready_last;
        int   lat;
        bit   seen;
        do_reset(1);
        for (int r = 0; r < 3; r++) begin
            ready_last = (r == 1);
            i_req  = 1'b1;
            i_addr = 32'h20 + r;
            step();
            i_req = 1'b0;
            total++;
            if (rr_i_gnt !== 1'b1) begin
                bad++;
                $display("FAIL wd_gnt r=%0d: got=%b exp=1", r, rr_i_gnt);
            end
            mem_rdata = 32'h5555_0000 + r;
            if (ready_last)
                sb_q.push_back('{port: 1'b0, data: 32'h5555_0000 + r, err: 1'b0});
            else
                sb_q.push_back('{port: 1'b0, data: 32'h0, err: 1'b1});
            seen = 1'b0;
            lat  = 0;
            for (int k = 1; k <= 10 && !seen; k++) begin
                mem_ready = (ready_last && k == 4);
                step();
                mem_ready = 1'b0;
                if (rr_i_rvalid === 1'b1) begin
                    seen = 1'b1;
                    lat  = k;
                    e    = sb_q.pop_front();
                    total++;
                    if (rr_i_rdata !== e.data || rr_i_err !== e.err || rr_mem_req !== 1'b0) begin
                        bad++;
                        $display("FAIL wd_result r=%0d: got rdata=%h err=%b mem_req=%b exp %h/%b/0",
                                 r, rr_i_rdata, rr_i_err, rr_mem_req, e.data, e.err);
                    end
                end
            end
            total++;
            if (!seen || lat != 4) begin
                bad++;
                $display("FAIL wd_latency r=%0d: got seen=%0d lat=%0d exp seen=1 lat=4", r, seen, lat);
            end
            step();
            total++;
            if (rr_i_rdata !== e.data || rr_i_err !== 1'b0 || rr_i_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL wd_hold r=%0d: got rdata=%h err=%b rvalid=%b exp %h/0/0",
                         r, rr_i_rdata, rr_i_err, rr_i_rvalid, e.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        // a completed fetch leaves last_owner = I
        i_req = 1'b1;
        step();
        i_req     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_0000;
        step();
        mem_ready = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h40;
        step();
        d_req = 1'b0;
        total++;
        if (rr_d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mid_dgnt: got=%b exp=1", rr_d_gnt);
        end
        step();
        reset     = 1'b1;
        mem_ready = 1'b1;
        step();
        reset     = 1'b0;
        mem_ready = 1'b0;
        total++;
        if ({rr_i_rvalid, rr_d_rvalid, rr_mem_req} !== 3'b000) begin
            bad++;
            $display("FAIL mid_after_reset: got=%b exp=000", {rr_i_rvalid, rr_d_rvalid, rr_mem_req});
        end
        step();
        total++;
        if ({rr_i_rvalid, rr_d_rvalid, rr_mem_req} !== 3'b000) begin
            bad++;
            $display("FAIL mid_quiet: got=%b exp=000", {rr_i_rvalid, rr_d_rvalid, rr_mem_req});
        end
        i_req = 1'b1;
        d_req = 1'b1;
        step();
        i_req = 1'b0;
        d_req = 1'b0;
        total++;
        if ({rr_i_gnt, rr_d_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL mid_first_tie: got=%b exp=10", {rr_i_gnt, rr_d_gnt});
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_tie(1'b0);
        test_tie(1'b1);
        test_store();
        test_watchdog();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=expired exp=finished");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between two requesters: instruction fetch (port I) and load/store (port D).
- Allows the core to use one unified instruction/data memory instead of separate instruction and data memories.
- Sits between the fetch/LSU logic and the memory.
- Serialises transactions, one outstanding at a time, with a selectable arbitration policy and a completion watchdog.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port D always wins a tie.
- TIMEOUT, 64: cycles allowed in BUSY before abort; 0 disables the watchdog. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address. Port I is read-only, width word.
- i_gnt  out  1  fetch accepted (1-cycle pulse).
- i_rvalid  out  1  fetch complete (1-cycle pulse).
- i_rdata  out  DATA_W  fetch data, valid with i_rvalid.
- i_err  out  1  fetch timed out, valid with i_rvalid.
- d_req  in  1  data request.
- d_we  in  1  1 = store.
- d_width  in  3  funct3 width code (byte/half/word, signed/unsigned).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt, d_rvalid, d_rdata, d_err  out  same as the port I counterparts.
- mem_req  out  1  transaction active at memory.
- mem_we  out  1  memory write enable.
- mem_width  out  3  memory width code.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory completes the current transaction this cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.

Behaviour:
- Reset, synchronous and active-high, one clock and no other clocks. On reset:
  - state = IDLE.
  - All gnt/rvalid/err outputs and mem_req = 0.
  - mem_* and rdata registers = 0.
  - last_owner = D, so I wins the first tie.
  - Watchdog = 0.
  - Reset mid-transaction discards that transaction; no rvalid is produced.
- States: IDLE, BUSY. All outputs are registered.
- IDLE, no request: stay in IDLE; outputs hold 0.
- IDLE, any request in cycle N. At the edge:
  - Select owner. A single requester wins.
  - On a tie: FIXED_PRIO=1 selects D; FIXED_PRIO=0 selects the port that is not last_owner.
  - Latch owner's addr/we/width/wdata into mem_*. Port I forces we=0 and width=3'b010.
  - mem_req <= 1, owner's gnt <= 1 (high in cycle N+1 only), state <= BUSY, watchdog <= 0.
- BUSY:
  - mem_req and mem_* are held stable.
  - Requests are ignored; a losing requester keeps req high and waits.
  - A request still high in the cycle after its gnt counts as a new request.
- BUSY, mem_ready=1 in cycle M. At the edge:
  - Owner's rvalid <= 1 for cycle M+1.
  - Owner's rdata <= mem_rdata for loads, 0 for stores.
  - err <= 0, mem_req <= 0, last_owner <= owner, state <= IDLE.
- Arbitration may occur again in cycle M+1, which gives a back-to-back throughput of 1 transaction per 2 cycles minimum. mem_ready may already be 1 in the first BUSY cycle.
- Watchdog:
  - Increments each BUSY cycle without mem_ready.
  - When TIMEOUT≠0 and the count reaches TIMEOUT-1 with mem_ready=0: complete as above, with rvalid=1, err=1, rdata=0.
  - mem_ready in the same cycle takes precedence: normal completion, err=0.
- mem_ready in IDLE is ignored.
- rdata registers hold their value until the next completion for that port.
- gnt and rvalid never assert for both ports in the same cycle.

Decomposition:
- Shared package riscv_pkg:
  - arb_state_t enum {IDLE, BUSY}.
  - arb_port_t enum {PORT_I, PORT_D}.
  - Width constants W_BYTE=3'b000, W_HALF=3'b001, W_WORD=3'b010, W_BU=3'b100, W_HU=3'b101, shared with data_memory.
- One sub-module, arb_pick: combinational 2-way pick from (i_req, d_req, last_owner, FIXED_PRIO) -> owner, valid.
- The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Reset + single fetch:
  - Reset 2 cycles, then i_req=1, i_addr=0x0000_0010 at N, mem_ready=1 at N+2, mem_rdata=0x0050_0093.
  - Expect i_gnt at N+1; mem_addr=0x10, mem_we=0, mem_width=3'b010; i_rvalid at N+3 with i_rdata=0x0050_0093, i_err=0.
- Tie round-robin, FIXED_PRIO=0:
  - i_req and d_req held high; mem_ready=1 on every BUSY cycle.
  - Expect grant order I, D, I, D with gnt pulses 2 cycles apart.
- Tie with FIXED_PRIO=1:
  - Same stimulus.
  - Expect D granted every time; I starves while d_req stays high.
- Store:
  - d_req=1, d_we=1, d_width=3'b000, d_addr=0x0000_0103, d_wdata=0xAB.
  - Expect mem_we=1, mem_width=0, mem_addr=0x103, mem_wdata=0xAB; d_rvalid with d_rdata=0.
- Watchdog, TIMEOUT=4:
  - Fetch, mem_ready never asserted.
  - Expect i_rvalid=1, i_err=1, i_rdata=0 exactly 4 cycles after i_gnt; mem_req=0 next cycle.
  - Repeat with mem_ready=1 on the final cycle: expect i_err=0.
- Reset mid-transaction:
  - Assert reset for 1 cycle while BUSY.
  - Expect no rvalid, mem_req=0 the next cycle, and the first post-reset tie granted to I.
